// File: rtl/leaf_sched_pkg.sv
// Shared constants and types for the leaf output scheduler: packet field
// offsets, destination-table entry and credit width.
package leaf_sched_pkg;

  localparam int unsigned PACKET_BITS   = 49;
  localparam int unsigned PAYLOAD_BITS  = 32;
  localparam int unsigned NUM_LEAF_BITS = 5;
  localparam int unsigned NUM_PORT_BITS = 4;
  localparam int unsigned NUM_ADDR_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;
  localparam int unsigned NUM_OUT_PORTS = 6;
  localparam int unsigned CREDIT_BITS   = NUM_ADDR_BITS + 1;
  localparam int unsigned INIT_CREDIT   = 2 ** NUM_ADDR_BITS;

  // Packet field positions: {valid, leaf, port, addr, payload}
  localparam int unsigned VALID_BIT = 48;
  localparam int unsigned LEAF_LSB  = 43;
  localparam int unsigned PORT_LSB  = 39;
  localparam int unsigned ADDR_LSB  = 32;

  typedef struct packed {
    logic                     configured;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] dport;
  } dest_entry_t;

endpackage

// File: rtl/leaf_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching from ptr with wrap,
// pointer advances past the winner and holds when nothing is granted.
module leaf_rr_arbiter #(
  parameter int unsigned N  = 6,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic          gnt_vld_c,
  output logic [IW-1:0] gnt_idx_c
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;

  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    cand      = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(off);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!gnt_vld_c && req[cand[IW-1:0]]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = cand[IW-1:0];
      end
    end
    ptr_d = ptr_q;
    if (gnt_vld_c) ptr_d = (gnt_idx_c == IW'(N - 1)) ? '0 : gnt_idx_c + IW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/leaf_out_sched.sv
// Leaf output scheduler: round-robin share of the packet link with per-port
// credits, address counters and destination table. LEAF_SCHED_PERF_EN adds
// per-port sent/stall counters.
module leaf_out_sched
  import leaf_sched_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_user,
  input  logic                                  resend,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_sel,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dport,
  input  logic                                  cr_upd_vld,
  input  logic [NUM_PORT_BITS-1:0]              cr_upd_sel,
  input  logic [CREDIT_BITS-1:0]                cr_upd_amt,
`ifdef LEAF_SCHED_PERF_EN
  input  logic [NUM_PORT_BITS-1:0]              perf_sel,
  output logic [31:0]                           perf_sent,
  output logic [31:0]                           perf_stall,
`endif
  output logic [PACKET_BITS-1:0]                pkt_out
);

  localparam int unsigned IDX_BITS = $clog2(NUM_OUT_PORTS);
  localparam int unsigned SUM_BITS = CREDIT_BITS + 1;

  dest_entry_t              entry_q  [NUM_OUT_PORTS];
  dest_entry_t              entry_d  [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_d   [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0]  payload  [NUM_OUT_PORTS];
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic [NUM_OUT_PORTS-1:0] elig_c;
  logic                     gnt_vld_c;
  logic [IDX_BITS-1:0]      gnt_idx_c;
  logic                     hit, upd;
  logic [SUM_BITS-1:0]      sum;

  always_comb begin
    elig_c  = '0;
    payload = '{default: '0};
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      payload[i] = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      elig_c[i]  = vld_user[i] & entry_q[i].configured & (credit_q[i] != '0) & ~resend;
    end
  end

  leaf_rr_arbiter #(
    .N  (NUM_OUT_PORTS),
    .IW (IDX_BITS)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (elig_c),
    .gnt_vld_c (gnt_vld_c),
    .gnt_idx_c (gnt_idx_c)
  );

  assign ack_user = gnt_vld_c ? (NUM_OUT_PORTS'(1) << gnt_idx_c) : '0;

  // Packet formation plus credit/address/table next state
  always_comb begin
    entry_d  = entry_q;
    credit_d = credit_q;
    addr_d   = addr_q;
    pkt_d    = '0;
    hit      = 1'b0;
    upd      = 1'b0;
    sum      = '0;
    if (gnt_vld_c) begin
      pkt_d[VALID_BIT]                     = 1'b1;
      pkt_d[LEAF_LSB +: NUM_LEAF_BITS]     = entry_q[gnt_idx_c].leaf;
      pkt_d[PORT_LSB +: NUM_PORT_BITS]     = entry_q[gnt_idx_c].dport;
      pkt_d[ADDR_LSB +: NUM_ADDR_BITS]     = addr_q[gnt_idx_c];
      pkt_d[PAYLOAD_BITS-1:0]              = payload[gnt_idx_c];
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      hit = gnt_vld_c && (gnt_idx_c == IDX_BITS'(i));
      upd = cr_upd_vld && (cr_upd_sel == NUM_PORT_BITS'(i));
      // Grant never underflows: a zero-credit port is not eligible
      sum = SUM_BITS'(credit_q[i]) - SUM_BITS'(hit) + (upd ? SUM_BITS'(cr_upd_amt) : '0);
      credit_d[i] = (sum > SUM_BITS'(INIT_CREDIT)) ? CREDIT_BITS'(INIT_CREDIT) : CREDIT_BITS'(sum);
      if (hit) addr_d[i] = addr_q[i] + NUM_ADDR_BITS'(1);
      if (cfg_we && (cfg_sel == NUM_PORT_BITS'(i)))
        entry_d[i] = '{configured: 1'b1, leaf: cfg_leaf, dport: cfg_dport};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        entry_q[i]  <= '0;
        credit_q[i] <= CREDIT_BITS'(INIT_CREDIT);
        addr_q[i]   <= '0;
      end
      pkt_q <= '0;
    end else begin
      entry_q  <= entry_d;
      credit_q <= credit_d;
      addr_q   <= addr_d;
      pkt_q    <= pkt_d;
    end
  end

  assign pkt_out = pkt_q;

`ifdef LEAF_SCHED_PERF_EN
  logic [31:0] sent_q  [NUM_OUT_PORTS];
  logic [31:0] stall_q [NUM_OUT_PORTS];
  logic [31:0] perf_sent_q, perf_stall_q;

  // Free-running wrap-around counters with a registered readout mux
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        sent_q[i]  <= '0;
        stall_q[i] <= '0;
      end
      perf_sent_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (ack_user[i]) sent_q[i] <= sent_q[i] + 32'd1;
        if (vld_user[i] && entry_q[i].configured && (credit_q[i] == '0))
          stall_q[i] <= stall_q[i] + 32'd1;
      end
      if (perf_sel < NUM_PORT_BITS'(NUM_OUT_PORTS)) begin
        perf_sent_q  <= sent_q[IDX_BITS'(perf_sel)];
        perf_stall_q <= stall_q[IDX_BITS'(perf_sel)];
      end else begin
        perf_sent_q  <= '0;
        perf_stall_q <= '0;
      end
    end
  end

  assign perf_sent  = perf_sent_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
